// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
//   statetype  : arbiter FSM states (IDLE, BUSY)
//   NREQ       : number of requesters
//   rr_search  : rotating-priority winner search over a candidate mask
package arb_pkg;

  typedef enum logic {IDLE, BUSY} statetype;

  localparam int NREQ = 8;

  // Scans start, start+1, ... start+7 (mod 8) and returns the first index
  // whose mask bit is set. The return value is meaningless for an all-zero
  // mask; callers only use it when the mask is nonzero.
  function automatic logic [2:0] rr_search(input logic [NREQ-1:0] mask,
                                           input logic [2:0]      start);
    logic [2:0] idx;
    logic       found;
    rr_search = start;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = start + 3'(i);
      if (!found && mask[idx]) begin
        rr_search = idx;
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder.
//   idx    : binary index in
//   onehot : one-hot vector with bit idx set
module decoder3_8
  import arb_pkg::*;
(
  input  logic [2:0]      idx,
  output logic [NREQ-1:0] onehot
);

  assign onehot = NREQ'(1) << idx;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   req       : request vector, bit i = requester i
//   grant     : one-hot grant, zero when nobody owns the resource
//   gnt_idx   : index of the current owner (meaningful when gnt_valid)
//   gnt_valid : a grant is active
// The owner keeps the grant until it drops its request, or until it has held
// it for MAXHOLD cycles while someone else is waiting. Handover to the next
// winner happens on the same edge, so there are no gap cycles.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAXHOLD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      gnt_idx,
  output logic            gnt_valid
);

  localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);

  statetype        state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] others;
  logic            tenure_release;
  logic            tenure_expire;

  // The same one-hot vector feeds both the grant output and the others mask.
  decoder3_8 u_dec (
    .idx    (owner_q),
    .onehot (owner_oh)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    others         = req & ~owner_oh;
    tenure_release = !req[owner_q];
    // A lone owner never expires; only contention bounds the tenure.
    tenure_expire  = (hold_cnt_q == HOLD_LAST) && (others != '0);

    case (state_q)
      IDLE: begin
        // ptr is intentionally left alone here; it only moves at end of tenure.
        if (req != '0) begin
          owner_d    = rr_search(req, ptr_q);
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (tenure_release || tenure_expire) begin
          ptr_d = owner_q + 3'd1;
          if (others != '0) begin
            owner_d    = rr_search(others, owner_q + 3'd1);
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_valid = (state_q == BUSY);
  assign gnt_idx   = owner_q;
  assign grant     = gnt_valid ? owner_oh : '0;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8 (built with MAXHOLD = 4).
module tb_rr_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int vectors;
  int miscompares;

  rr_arbiter8 #(.MAXHOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = 8'h00;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (grant !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_grant: got %h expected %h", grant, 8'h00);
    end
    vectors++;
    if (gnt_idx !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idx: got %0d expected %0d", gnt_idx, 0);
    end
    vectors++;
    if (gnt_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid: got %b expected %b", gnt_valid, 1'b0);
    end
    reset = 1'b0;
    tick(1);
    vectors++;
    if (grant !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL post_reset_grant: got %h expected %h", grant, 8'h01);
    end
    vectors++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idx: got idx %0d valid %b expected idx 0 valid 1",
               gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_single;
    do_reset();
    req = 8'h20;
    tick(1);
    vectors++;
    if (grant !== 8'h20 || gnt_idx !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got %h idx %0d expected %h idx 5", grant, gnt_idx, 8'h20);
    end
    for (int k = 0; k < 100; k++) begin
      tick(1);
      vectors++;
      if (grant !== 8'h20) begin
        miscompares++;
        $display("[TB] FAIL single_hold[%0d]: got %h expected %h", k, grant, 8'h20);
      end
    end
    req = 8'h00;
    tick(1);
    vectors++;
    if (grant !== 8'h00 || gnt_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_release: got %h valid %b expected 00 valid 0", grant, gnt_valid);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    req = 8'h81;
    tick(1);
    vectors++;
    if (grant !== 8'h01 || gnt_idx !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL rr_first: got %h idx %0d expected %h idx 0", grant, gnt_idx, 8'h01);
    end
    req = 8'h80;
    tick(1);
    vectors++;
    if (grant !== 8'h80 || gnt_idx !== 3'd7) begin
      miscompares++;
      $display("[TB] FAIL rr_handover: got %h idx %0d expected %h idx 7", grant, gnt_idx, 8'h80);
    end
    req = 8'h01;
    tick(1);
    vectors++;
    if (grant !== 8'h01 || gnt_idx !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL rr_wrap: got %h idx %0d expected %h idx 0", grant, gnt_idx, 8'h01);
    end
    req = 8'h00;
    tick(1);
    vectors++;
    if (grant !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL rr_idle: got %h expected %h", grant, 8'h00);
    end
  endtask

  task automatic test_preempt;
    logic [7:0] exp_g;
    do_reset();
    req = 8'h06;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      exp_g = (k < 4) ? 8'h02 : ((k < 8) ? 8'h04 : 8'h02);
      vectors++;
      if (grant !== exp_g) begin
        miscompares++;
        $display("[TB] FAIL preempt[%0d]: got %h expected %h", k, grant, exp_g);
      end
    end
    req = 8'h00;
    tick(1);
  endtask

  task automatic test_simultaneous;
    do_reset();
    req = 8'h08;
    tick(1);
    vectors++;
    if (grant !== 8'h08) begin
      miscompares++;
      $display("[TB] FAIL simul_owner3: got %h expected %h", grant, 8'h08);
    end
    req = 8'h22;
    tick(1);
    vectors++;
    if (grant !== 8'h20 || gnt_idx !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL simul_next: got %h idx %0d expected %h idx 5", grant, gnt_idx, 8'h20);
    end
    req = 8'h00;
    tick(1);
  endtask

  task automatic test_back_to_back;
    do_reset();
    req = 8'h40;
    tick(2);
    vectors++;
    if (grant !== 8'h40 || gnt_idx !== 3'd6) begin
      miscompares++;
      $display("[TB] FAIL midreset_owner6: got %h idx %0d expected %h idx 6", grant, gnt_idx, 8'h40);
    end
    reset = 1'b1;
    tick(1);
    vectors++;
    if (grant !== 8'h00 || gnt_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_grant: got %h valid %b expected 00 valid 0", grant, gnt_valid);
    end
    vectors++;
    if (dut.ptr_q !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_ptr: got %0d expected %0d", dut.ptr_q, 0);
    end
    reset = 1'b0;
    req   = 8'h41;
    tick(1);
    vectors++;
    if (grant !== 8'h01 || gnt_idx !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_rearb: got %h idx %0d expected %h idx 0", grant, gnt_idx, 8'h01);
    end
    req = 8'h00;
    tick(1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req         = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_simultaneous();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter for a shared resource: up to eight requesters raise `req` bits and exactly one at a time receives a one-hot `grant`. The winner keeps the grant until it drops its request or hits a hold limit while others wait. The winner's 3-bit index is kept in a register and turned into the one-hot grant vector by the team's 3-to-8 decoder. The block sits in front of any single-ported resource (bus, memory port, ALU) shared by up to eight agents.

## Interface
- `MAXHOLD`, default 16: maximum consecutive cycles one owner may hold the grant while another request is pending. Legal range is 1..256.
- `clk` input, 1 bit: the only clock. All state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `req` input, 8 bits: request vector. Bit i is requester i. A requester holds its bit high until it is done.
- `grant` output, 8 bits: one-hot grant. All zero when no one is granted.
- `gnt_idx` output, 3 bits: index of the current owner. Valid only when `gnt_valid` is 1.
- `gnt_valid` output, 1 bit: high while a grant is active.

## Operation
- Registers:
  - `state`, with values IDLE and BUSY.
  - `owner`, 3 bits.
  - `ptr`, 3 bits: round-robin start point.
  - `hold_cnt`, width `$clog2(MAXHOLD)`, minimum 1 bit.
- Outputs are driven from registers only:
  - `gnt_valid = (state==BUSY)`.
  - `gnt_idx = owner`.
  - `grant = gnt_valid ? decode(owner) : 8'b0`.
- Winner search, given a candidate mask:
  - Scan indices ptr, ptr+1, … ptr+7, modulo 8.
  - The first index with its mask bit set wins.
  - Wrap from 7 to 0 is required.
- IDLE:
  - If `req` is not zero, winner = search(`req`).
  - Set `owner` to the winner, clear `hold_cnt`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, every cycle:
  - `others = req & ~decode(owner)`.
  - `release = !req[owner]`.
  - `expire = (hold_cnt == MAXHOLD-1) && (others != 0)`.
- BUSY, end of tenure (`release` or `expire`):
  - Set `ptr = owner + 1` (mod 8).
  - If `others` is not zero: move to a new owner with no idle cycle. The new owner is the winner searched from the updated ptr (owner+1) over `others`. Clear `hold_cnt` and stay in BUSY.
  - Otherwise: go to IDLE.
- BUSY, no end of tenure:
  - `hold_cnt` increments, saturating at MAXHOLD-1.
  - `hold_cnt` does not expire a lone owner: a lone requester keeps the grant indefinitely.
- A preempted owner that still has `req` high competes again in later searches. Round-robin order places it last.
- `ptr` does not change on the IDLE→BUSY transition. It changes only at end of tenure.
- Reset values: `state`=IDLE, `owner`=0, `ptr`=0, `hold_cnt`=0, `grant`=0, `gnt_idx`=0, `gnt_valid`=0.
- `reset` has priority over all other events. Asserting it during BUSY removes the grant on the next edge and loses no requests: requesters simply re-arbitrate after reset.

## Timing
- Grant latency: `req` seen in IDLE at edge N → `grant` asserted after edge N (one cycle).
- Release latency: owner drops `req` before edge M → `grant` to it removed after edge M.
- At the same edge, the next winner's `grant` appears if `others` is nonzero, so there are no gap cycles.
- Preemption: an owner granted at edge G with others pending throughout loses the grant after edge G+MAXHOLD, i.e. after exactly MAXHOLD grant cycles.
- `grant` is always one-hot or zero, and never glitches between registered values.
- Release and expire in the same cycle are handled as a single end of tenure.
- Requests arriving in the same cycle as a release take part in that cycle's handover search.

## Structure
- Package `arb_pkg` holds:
  - `typedef enum logic {IDLE, BUSY} statetype;`
  - `localparam NREQ = 8;`
- The sub-module `decoder3_8` is instantiated once to turn `owner` into the one-hot vector. That one-hot vector is used both for the `grant` output and for the `others` mask.
- The rotating priority search is a combinational function in the package, shared by the IDLE and handover paths.

## Test plan
- **Reset:** hold `reset` 2 cycles with `req`=8'hFF → all outputs 0. Release reset → `grant`=8'h01 and `gnt_idx`=0 one cycle later.
- **Single requester:** `req`=8'h20 → `grant`=8'h20 after 1 cycle. Keep it high for 100 cycles → `grant` stays 8'h20 with no preemption. Drop `req` → `grant`=0 the next cycle.
- **Round-robin handover:**
  - `req`=8'h81 constant from IDLE with ptr=0 → owner 0.
  - Drop bit 0 → `grant`=8'h80 with no gap.
  - Re-raise bit 0 and drop bit 7 → wrap-around, `grant`=8'h01.
- **Preemption** with MAXHOLD=4: `req`=8'h06 held → `grant` sequence is 8'h02 for 4 cycles, then 8'h04 for 4 cycles, then 8'h02 again.
- **Simultaneous events:** owner 3 releases in the same cycle that `req` bits 1 and 5 rise → next grant is 8'h20 (search starts at 4).
- **Reset mid-tenure:** assert `reset` during BUSY at owner 6 → `grant`=0 after the edge and `ptr`=0. With `req`=8'h41 after reset → `grant`=8'h01.
